// File: rtl/pad_keypad_model_if.sv
// pad_keypad_model_if: press-command handshake between a controller and the keypad emulator
interface pad_keypad_model_if;
  logic cmd_valid;
  logic cmd_ready;
  logic [3:0] key_idx;
  logic [15:0] hold_len;
  logic busy;
  logic done;
  logic err;
  modport master (output cmd_valid, key_idx, hold_len, input cmd_ready, busy, done, err);
  modport slave (input cmd_valid, key_idx, hold_len, output cmd_ready, busy, done, err);
endinterface

// File: rtl/pad_keypad_model.sv
// pad_keypad_model: 4x3 matrix-keypad emulator answering row strobes with bouncing column returns
module pad_keypad_model #(
  parameter int BOUNCE_CYCLES = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic clk,
  input  logic rst,
  input  logic [0:3] pad_pos,
  output logic [0:2] pad,
  pad_keypad_model_if.slave cmd
);
  localparam int BW = $clog2(BOUNCE_CYCLES + 1);
  localparam logic [BW-1:0] BINIT = BW'(BOUNCE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT} state_t;
  state_t state;
  logic [7:0] lfsr;
  logic [BW-1:0] bcnt;
  logic [15:0] hcnt;
  logic [3:0] key;
  logic [1:0] row, col;
  logic contact, done_q, err_q;
  always_comb begin
    row = key < 4'd3 ? 2'd0 : key < 4'd6 ? 2'd1 : key < 4'd9 ? 2'd2 : 2'd3;
    col = 2'(key - 4'(row) * 4'd3);
    contact = state == HOLD ? 1'b1 : state == IDLE ? 1'b0 : lfsr[0];
  end
  assign cmd.busy = state != IDLE;
  assign cmd.cmd_ready = state == IDLE;
  assign cmd.done = done_q;
  assign cmd.err = err_q;
  // hcnt is loaded at accept and simply waits through BOUNCE_IN until HOLD starts
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pad <= '0;
      done_q <= 1'b0;
      err_q <= 1'b0;
      lfsr <= LFSR_SEED;
      bcnt <= '0;
      hcnt <= '0;
      key <= '0;
    end else begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      pad <= (contact && pad_pos[row]) ? 3'b100 >> col : 3'b000;
      done_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        IDLE:
          if (cmd.cmd_valid) begin
            if (cmd.key_idx >= 4'd12) err_q <= 1'b1;
            else begin
              key <= cmd.key_idx;
              hcnt <= cmd.hold_len == 16'd0 ? 16'd0 : cmd.hold_len - 16'd1;
              bcnt <= BINIT;
              state <= BOUNCE_IN;
            end
          end
        BOUNCE_IN:
          if (bcnt == '0) state <= HOLD;
          else bcnt <= bcnt - 1'b1;
        HOLD:
          if (hcnt == 16'd0) begin
            state <= BOUNCE_OUT;
            bcnt <= BINIT;
          end else hcnt <= hcnt - 16'd1;
        default:
          if (bcnt == '0) begin
            state <= IDLE;
            done_q <= 1'b1;
          end else bcnt <= bcnt - 1'b1;
      endcase
    end
  end
endmodule

// File: tb/tb_pad_keypad_model.sv
// tb_pad_keypad_model: table-driven press vectors plus back-to-back and mid-hold reset sequences
module tb_pad_keypad_model;
  logic clk = 1'b0;
  logic rst;
  logic [0:3] pad_pos;
  logic [0:2] pad;
  logic [7:0] m;
  int pass_cnt = 0, total_cnt = 0, cyc = 0;
  pad_keypad_model_if cmd ();
  pad_keypad_model dut (.clk(clk), .rst(rst), .pad_pos(pad_pos), .pad(pad), .cmd(cmd));
  always #5 clk = ~clk;
  // reference LFSR: Fibonacci, taps 8,6,5,4, bit 0 is the contact value
  always @(posedge clk) m <= rst ? 8'hA5 : {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
  typedef struct {
    logic [3:0] key;
    logic [15:0] hold;
    logic [0:3] pos;
    bit rr;
    bit err;
    int lat;
  } vec_t;
  vec_t tbl[6];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    else pass_cnt++;
  endtask
  task automatic press(input vec_t v);
    int row, col, i;
    logic pm, ct;
    logic [0:3] pp;
    logic [2:0] ep;
    row = int'(v.key) / 3;
    col = int'(v.key) % 3;
    @(negedge clk);
    chk("ready_before", 32'(cmd.cmd_ready), 32'd1);
    cmd.cmd_valid = 1'b1;
    cmd.key_idx = v.key;
    cmd.hold_len = v.hold;
    pad_pos = v.rr ? 4'b1000 >> (cyc % 4) : v.pos;
    pp = pad_pos;
    pm = m[0];
    for (int j = 0; j <= v.lat + 1; j++) begin
      @(negedge clk);
      cyc++;
      cmd.cmd_valid = 1'b0;
      i = j - 1;
      ct = (i < 0 || i >= v.lat) ? 1'b0 : (i <= 7 || i >= v.lat - 8) ? pm : 1'b1;
      ep = (ct && pp[row]) ? 3'b100 >> col : 3'b000;
      chk($sformatf("pad k%0d j%0d", v.key, j), 32'(pad), 32'(ep));
      chk($sformatf("busy k%0d j%0d", v.key, j), 32'(cmd.busy), 32'(j < v.lat));
      chk($sformatf("done k%0d j%0d", v.key, j), 32'(cmd.done), 32'(j == v.lat));
      pad_pos = v.rr ? 4'b1000 >> (cyc % 4) : v.pos;
      pp = pad_pos;
      pm = m[0];
    end
  endtask
  task automatic reject(input vec_t v);
    @(negedge clk);
    cmd.cmd_valid = 1'b1;
    cmd.key_idx = v.key;
    @(negedge clk);
    cmd.cmd_valid = 1'b0;
    chk($sformatf("err_pulse k%0d", v.key), 32'(cmd.err), 32'd1);
    chk($sformatf("err_busy k%0d", v.key), 32'(cmd.busy), 32'd0);
    chk($sformatf("err_ready k%0d", v.key), 32'(cmd.cmd_ready), 32'd1);
    @(negedge clk);
    chk($sformatf("err_end k%0d", v.key), 32'(cmd.err), 32'd0);
    chk($sformatf("err_idle k%0d", v.key), 32'(cmd.busy), 32'd0);
  endtask
  initial begin
    int d1, d2;
    bit seen;
    tbl[0] = '{key: 4'd5, hold: 16'd20, pos: 4'b0000, rr: 1'b1, err: 1'b0, lat: 36};
    tbl[1] = '{key: 4'd0, hold: 16'd5, pos: 4'b1000, rr: 1'b0, err: 1'b0, lat: 21};
    tbl[2] = '{key: 4'd12, hold: 16'd4, pos: 4'b0000, rr: 1'b0, err: 1'b1, lat: 0};
    tbl[3] = '{key: 4'd15, hold: 16'd4, pos: 4'b0000, rr: 1'b0, err: 1'b1, lat: 0};
    tbl[4] = '{key: 4'd4, hold: 16'd0, pos: 4'b0100, rr: 1'b0, err: 1'b0, lat: 17};
    tbl[5] = '{key: 4'd11, hold: 16'd3, pos: 4'b0000, rr: 1'b1, err: 1'b0, lat: 19};
    rst = 1'b1;
    pad_pos = 4'b0000;
    cmd.cmd_valid = 1'b0;
    cmd.key_idx = 4'd0;
    cmd.hold_len = 16'd0;
    repeat (2) @(negedge clk);
    chk("rst_pad", 32'(pad), 32'd0);
    chk("rst_ready", 32'(cmd.cmd_ready), 32'd1);
    chk("rst_busy", 32'(cmd.busy), 32'd0);
    chk("rst_done", 32'(cmd.done), 32'd0);
    chk("rst_err", 32'(cmd.err), 32'd0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      if (tbl[t].err) reject(tbl[t]);
      else press(tbl[t]);
    end
    // back-to-back: cmd_valid stays high through the done cycle
    @(negedge clk);
    pad_pos = 4'b0000;
    cmd.cmd_valid = 1'b1;
    cmd.key_idx = 4'd1;
    cmd.hold_len = 16'd3;
    d1 = -1;
    for (int j = 0; j < 40 && d1 < 0; j++) begin
      @(negedge clk);
      if (cmd.done) d1 = j;
    end
    chk("b2b_first_done", 32'(d1), 32'd19);
    chk("b2b_gap_busy", 32'(cmd.busy), 32'd0);
    chk("b2b_gap_ready", 32'(cmd.cmd_ready), 32'd1);
    cmd.key_idx = 4'd2;
    cmd.hold_len = 16'd2;
    @(negedge clk);
    chk("b2b_accept_busy", 32'(cmd.busy), 32'd1);
    chk("b2b_accept_done", 32'(cmd.done), 32'd0);
    cmd.cmd_valid = 1'b0;
    d2 = -1;
    for (int k = 1; k < 40 && d2 < 0; k++) begin
      @(negedge clk);
      if (cmd.done) d2 = k;
    end
    chk("b2b_second_done", 32'(d2), 32'd18);
    // reset in the middle of HOLD for key 7 (row 2, col 1)
    @(negedge clk);
    pad_pos = 4'b0010;
    cmd.cmd_valid = 1'b1;
    cmd.key_idx = 4'd7;
    cmd.hold_len = 16'd20;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      cmd.cmd_valid = 1'b0;
    end
    chk("hold_pad_k7", 32'(pad), 32'(3'b010));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_pad", 32'(pad), 32'd0);
    chk("abort_busy", 32'(cmd.busy), 32'd0);
    chk("abort_ready", 32'(cmd.cmd_ready), 32'd1);
    chk("abort_done", 32'(cmd.done), 32'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen |= cmd.done | cmd.busy;
    end
    chk("abort_quiet", 32'(seen), 32'd0);
    press('{key: 4'd3, hold: 16'd2, pos: 4'b0100, rr: 1'b0, err: 1'b0, lat: 18});
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
